// File: rtl/uart_mem_dump_pkg.sv
// Shared UART timing defaults and the bit-period derivation used by the serial blocks.
package uart_mem_dump_pkg;

    localparam int DEF_CLK_HZ = 25_000_000;
    localparam int DEF_BAUD   = 57600;

    // Integer-truncated clocks per serial bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, d0..d7 LSB first, stop bit, each held one bit period.
module uart_tx_byte
    import uart_mem_dump_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic       clk_ram,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       txd
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = $clog2(CPB + 1);

    logic          active_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [3:0]    bit_idx_reg;
    logic [7:0]    shreg_reg;
    logic          txd_reg;
    logic          bit_end;

    assign bit_end  = active_reg && (baud_cnt_reg == BW'(CPB - 1));
    assign tx_ready = !active_reg;
    assign tx_done  = bit_end && (bit_idx_reg == 4'd9);
    assign txd      = txd_reg;

    // bit_idx: 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            active_reg   <= 1'b0;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= 4'd0;
            shreg_reg    <= 8'h00;
            txd_reg      <= 1'b1;
        end else if (!active_reg) begin
            if (tx_valid) begin
                active_reg   <= 1'b1;
                shreg_reg    <= tx_data;
                bit_idx_reg  <= 4'd0;
                baud_cnt_reg <= '0;
                txd_reg      <= 1'b0;
            end
        end else if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 4'd9) begin
                active_reg <= 1'b0;
            end else begin
                bit_idx_reg <= bit_idx_reg + 4'd1;
                if (bit_idx_reg == 4'd8) begin
                    txd_reg <= 1'b1;
                end else begin
                    txd_reg   <= shreg_reg[0];
                    shreg_reg <= {1'b0, shreg_reg[7:1]};
                end
            end
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_mem_dump.sv
// RAM read-back over UART: on start, fetches DUMP_LEN bytes from DUMP_BASE one at a time
// through the ask_for_ram/ram_grant handshake and streams them out as 8N1 frames.
module uart_mem_dump
    import uart_mem_dump_pkg::*;
#(
    parameter int                    CLK_HZ     = DEF_CLK_HZ,
    parameter int                    BAUD       = DEF_BAUD,
    parameter int                    ADDR_WIDTH = 11,
    parameter logic [ADDR_WIDTH-1:0] DUMP_BASE  = 11'h200,
    parameter int                    DUMP_LEN   = 1024
) (
    input  logic                  clk_ram,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ask_for_ram,
    input  logic                  ram_grant,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [7:0]            ram_rdata,
    output logic                  serial_txd,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(DUMP_LEN + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    generate
        if (DUMP_LEN < 1) begin : g_len_check
            $error("uart_mem_dump: DUMP_LEN must be >= 1");
        end
    endgenerate

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             armed_reg;
    logic             last_byte;
    logic             tx_valid, tx_ready, tx_done;

    assign last_byte = (cnt_reg == CNT_W'(DUMP_LEN - 1));

    // armed_reg stays low for the first edge after reset release, so a start
    // coinciding with the release is not taken.
    always_ff @(posedge clk_ram or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            armed_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && armed_reg) begin
                    state_next = S_REQ;
                    cnt_next   = '0;
                end
            end
            S_REQ:   if (ram_grant) state_next = S_ADDR;
            S_ADDR:  state_next = ram_grant ? S_LATCH : S_REQ;
            // A lost grant discards the read; the same cnt is re-requested.
            S_LATCH: begin
                if (!ram_grant)    state_next = S_REQ;
                else if (tx_ready) state_next = S_SEND;
            end
            S_SEND: begin
                if (tx_done) begin
                    if (last_byte) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ask_for_ram = (state_reg == S_REQ) || (state_reg == S_ADDR) || (state_reg == S_LATCH);
        busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
        done        = (state_reg == S_DONE);
        tx_valid    = (state_reg == S_LATCH) && ram_grant && tx_ready;
        ram_raddr   = DUMP_BASE + ADDR_WIDTH'(cnt_reg);
    end

    uart_tx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_tx (
        .clk_ram  (clk_ram),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (ram_rdata),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .txd      (serial_txd)
    );

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed bench for uart_mem_dump: decodes serial frames and logs RAM addresses for two instances.
module tb_uart_mem_dump;

    localparam int CLK_HZ = 25_000_000;
    localparam int BAUD   = 2_000_000;
    localparam int CPB    = CLK_HZ / BAUD;   // 12 (12.5 truncated)
    localparam int HALF   = CPB / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start_w, grant, grant_w;
    logic        ask, txd, busy, done;
    logic        ask_w, txd_w, busy_w, done_w;
    logic [10:0] raddr, raddr_w;
    logic [7:0]  rdata, rdata_w;
    logic [7:0]  mem [0:2047];

    uart_mem_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(11), .DUMP_BASE(11'h200), .DUMP_LEN(4)) dut (
        .clk_ram(clk), .reset(rst_n), .start(start), .ask_for_ram(ask), .ram_grant(grant),
        .ram_raddr(raddr), .ram_rdata(rdata), .serial_txd(txd), .busy(busy), .done(done));

    uart_mem_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(11), .DUMP_BASE(11'h7FE), .DUMP_LEN(4)) dut_w (
        .clk_ram(clk), .reset(rst_n), .start(start_w), .ask_for_ram(ask_w), .ram_grant(grant_w),
        .ram_raddr(raddr_w), .ram_rdata(rdata_w), .serial_txd(txd_w), .busy(busy_w), .done(done_w));

    always @(posedge clk) begin
        rdata   <= mem[raddr];
        rdata_w <= mem[raddr_w];
    end

    // Grant model: grant follows ask after grant_delay cycles; optionally drops once
    // during the LATCH cycle of byte index 2.
    int grant_delay, wait_cnt, gh_cnt, req_idx, drop_hits;
    bit drop_mode, drop_done;
    logic ask_p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= 1'b0; wait_cnt <= 0; gh_cnt <= 0; req_idx <= 0; drop_done <= 1'b0; ask_p <= 1'b0;
        end else begin
            ask_p <= ask;
            if (start) begin
                req_idx <= 0; drop_done <= 1'b0;
            end else if (ask_p && !ask) begin
                req_idx <= req_idx + 1;
            end
            if (!ask) begin
                grant <= 1'b0; wait_cnt <= 0; gh_cnt <= 0;
            end else begin
                if (grant) gh_cnt <= gh_cnt + 1;
                if (wait_cnt >= grant_delay - 1) begin
                    if (drop_mode && !drop_done && req_idx == 2 && grant && gh_cnt == 1) begin
                        grant <= 1'b0; drop_done <= 1'b1; drop_hits <= drop_hits + 1;
                    end else begin
                        grant <= 1'b1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_w <= 1'b0;
        else        grant_w <= ask_w;
    end

    // Address log (address held on the last ask cycle), done counters, handshake monitors.
    logic        ask_q, grant_q, ask_wq;
    logic [10:0] raddr_q, raddr_wq;
    logic [10:0] alog [0:63];
    logic [10:0] alog_w [0:63];
    int alog_n, alog_wn, done_n, done_wn, viol_txd, viol_ask;
    always @(negedge clk) begin
        ask_q <= ask; grant_q <= grant; raddr_q <= raddr;
        ask_wq <= ask_w; raddr_wq <= raddr_w;
        if (rst_n) begin
            if (ask_q && !ask) begin
                if (alog_n < 64) alog[alog_n] <= raddr_q;
                alog_n <= alog_n + 1;
                if (!grant_q) viol_ask <= viol_ask + 1;
            end
            if (ask_wq && !ask_w) begin
                if (alog_wn < 64) alog_w[alog_wn] <= raddr_wq;
                alog_wn <= alog_wn + 1;
            end
            if (ask && !txd) viol_txd <= viol_txd + 1;
            if (done)   done_n  <= done_n + 1;
            if (done_w) done_wn <= done_wn + 1;
        end
    end

    // UART receiver for the main instance: mid-bit sampling, low-run and idle-gap measurement.
    int rx_frames, rx_t, rx_run, rx_idle, rx_stop_bad;
    bit rx_active, rx_run_open;
    logic [7:0] rx_sh;
    logic [7:0] rx_bytes [0:63];
    int rx_runs [0:63];
    int rx_gaps [0:63];
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active <= 1'b0; rx_idle <= 0;
        end else if (!rx_active) begin
            if (!txd) begin
                rx_active <= 1'b1; rx_t <= 1; rx_run <= 1; rx_run_open <= 1'b1;
                if (rx_frames < 64) rx_gaps[rx_frames] <= rx_idle - (CPB - HALF);
            end else begin
                rx_idle <= rx_idle + 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_run_open) begin
                if (!txd) rx_run <= rx_run + 1;
                else      rx_run_open <= 1'b0;
            end
            for (int k = 1; k <= 8; k++)
                if (rx_t + 1 == k * CPB + HALF) rx_sh[k-1] <= txd;
            if (rx_t + 1 == 9 * CPB + HALF) begin
                rx_active <= 1'b0; rx_idle <= 0;
                if (!txd) rx_stop_bad <= rx_stop_bad + 1;
                if (rx_frames < 64) begin
                    rx_bytes[rx_frames] <= rx_sh;
                    rx_runs[rx_frames]  <= rx_run;
                end
                rx_frames <= rx_frames + 1;
                $display("rx frame %0d: byte %02h, low run %0d", rx_frames, rx_sh, rx_run);
            end
        end
    end

    int n_checks, n_pass;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    logic [7:0]  exp_b [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    logic [10:0] exp_aw [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

    task automatic release_with_start(input string tag);
        #2 rst_n = 1'b1; start = 1'b1; start_w = 1'b1;
        @(negedge clk); start = 1'b0; start_w = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_rel_start_busy"}, busy, 1'b0);
        chk({tag, "_rel_start_ask"}, ask, 1'b0);
        chk({tag, "_rel_start_busy_w"}, busy_w, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int limit, input bit poke);
        int i = 0;
        while (!done && i < limit) begin @(negedge clk); i++; end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        if (poke) start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_done_1cyc"}, done, 1'b0);
    endtask

    task automatic do_dump(input string tag, input int exp_lat, input int probe, input bit poke);
        int lat = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1'b1);
        while (txd && lat < 500) begin
            @(negedge clk); lat++;
            if (lat == probe) begin
                chk({tag, "_ask_while_wait"}, ask, 1'b1);
                chk({tag, "_txd_idle_wait"}, txd, 1'b1);
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        if (poke) begin start = 1'b1; @(negedge clk); start = 1'b0; end
        wait_done(tag, 3000, poke);
    endtask

    task automatic check_stream(input string tag, input int fb, input int ab);
        chk({tag, "_nframes"}, rx_frames - fb, 4);
        chk({tag, "_naddr"}, alog_n - ab, 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s_byte%0d", tag, j), rx_bytes[fb + j], exp_b[j]);
            chk($sformatf("%s_addr%0d", tag, j), alog[ab + j], 11'h200 + 11'(j));
        end
    endtask

    int fb, ab, db, vt, va, hb, wi;
    initial begin
        rst_n = 1'b0; start = 1'b0; start_w = 1'b0; grant_delay = 1; drop_mode = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 8'(a * 7 + 3);
        mem[11'h200] = 8'h01; mem[11'h201] = 8'h80; mem[11'h202] = 8'hFF; mem[11'h203] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_ask", ask, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_raddr", raddr, 11'h200);
        chk("rst_raddr_w", raddr_w, 11'h7FE);
        chk("rst_txd_w", txd_w, 1'b1);
        release_with_start("t0");

        // 1: grant follows ask by one cycle
        fb = rx_frames; ab = alog_n; db = done_n; vt = rx_stop_bad;
        do_dump("t1", 4, 0, 1'b0);
        check_stream("t1", fb, ab);
        chk("t1_run0", rx_runs[fb], CPB);
        chk("t1_run1", rx_runs[fb + 1], 8 * CPB);
        chk("t1_run3", rx_runs[fb + 3], 9 * CPB);
        for (int j = 1; j < 4; j++) chk($sformatf("t1_gap%0d_ge3", j), rx_gaps[fb + j] >= 3, 1'b1);
        chk("t1_stop_bits", rx_stop_bad - vt, 0);
        chk("t1_done_count", done_n - db, 1);

        // 2: grant delayed 50 cycles on every request
        grant_delay = 50;
        fb = rx_frames; ab = alog_n; vt = viol_txd; va = viol_ask;
        do_dump("t2", 53, 25, 1'b0);
        check_stream("t2", fb, ab);
        chk("t2_txd_low_while_ask", viol_txd - vt, 0);
        chk("t2_ask_fell_ungranted", viol_ask - va, 0);
        grant_delay = 1;

        // 3: grant dropped during LATCH of byte 2
        drop_mode = 1'b1; hb = drop_hits;
        fb = rx_frames; ab = alog_n;
        do_dump("t3", 4, 0, 1'b0);
        check_stream("t3", fb, ab);
        chk("t3_drop_hit", drop_hits - hb, 1);
        drop_mode = 1'b0;

        // 4: address wrap past top of RAM
        ab = alog_wn; db = done_wn;
        start_w = 1'b1; @(negedge clk); start_w = 1'b0;
        chk("t4_busy_after_start", busy_w, 1'b1);
        wi = 0;
        while (!done_w && wi < 3000) begin @(negedge clk); wi++; end
        chk("t4_done", done_w, 1'b1);
        @(negedge clk);
        chk("t4_naddr", alog_wn - ab, 4);
        for (int j = 0; j < 4; j++) chk($sformatf("t4_addr%0d", j), alog_w[ab + j], exp_aw[j]);
        chk("t4_done_count", done_wn - db, 1);

        // 5: reset in the middle of byte 1
        fb = rx_frames;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wi = 0;
        while (!(rx_frames == fb + 1 && rx_active && rx_t >= 4 * CPB + HALF) && wi < 2000) begin
            @(negedge clk); wi++;
        end
        chk("t5_reached_byte1", rx_frames == fb + 1 && rx_active, 1'b1);
        chk("t5_txd_low_before", txd, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_txd", txd, 1'b1);
        chk("t5_async_ask", ask, 1'b0);
        chk("t5_async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        chk("t5_no_partial_frame", rx_frames - fb, 1);
        release_with_start("t5");
        fb = rx_frames; ab = alog_n;
        do_dump("t5", 4, 0, 1'b0);
        check_stream("t5", fb, ab);

        // 6: start while busy and during the DONE cycle
        fb = rx_frames; ab = alog_n; db = done_n;
        do_dump("t6", 4, 0, 1'b1);
        repeat (300) @(negedge clk);
        check_stream("t6", fb, ab);
        chk("t6_done_count", done_n - db, 1);
        chk("t6_idle_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
